// File: rtl/exhaustive_sweep_checker.sv
// rtl/exhaustive_sweep_checker.sv - clocked exhaustive operand sweep with output comparison
//
// Purpose: drives operands a/b through every 2W-bit combination in ascending
// order. Each vector is held for SETTLE cycles and then compared for one cycle
// between the block under test (y_dut) and the golden block (y_ref). The
// checker counts mismatching vectors and records the first failing index.
//
// Ports:
//   clk              in   clock; all state changes on the rising edge
//   rst              in   synchronous, active-high reset (priority over start)
//   start            in   begin a sweep; sampled only in IDLE or DONE
//   a_out  [W-1:0]   out  operand a (upper half of the vector index)
//   b_out  [W-1:0]   out  operand b (lower half of the vector index)
//   y_dut  [YW-1:0]  in   output of the block under test
//   y_ref  [YW-1:0]  in   output of the golden block
//   busy             out  high in APPLY and COMPARE
//   done             out  high in DONE
//   pass             out  high in DONE when no vector mismatched
//   mism_cnt [2W:0]  out  mismatching vectors in the current or last sweep
//   first_fail_valid out  a mismatch has been recorded
//   first_fail_vec [2W-1:0] out  index of the first mismatching vector
module exhaustive_sweep_checker #(
  parameter int W      = 2,
  parameter int YW     = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [W-1:0]    a_out,
  output logic [W-1:0]    b_out,
  input  logic [YW-1:0]   y_dut,
  input  logic [YW-1:0]   y_ref,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [2*W:0]    mism_cnt,
  output logic            first_fail_valid,
  output logic [2*W-1:0]  first_fail_vec
);

  localparam int VW = 2 * W;
  localparam int MW = 2 * W + 1;
  // Settle counter increments on every APPLY cycle, including the one that
  // leaves APPLY, so it must be able to hold the value SETTLE.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [VW-1:0]  vec_q, vec_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [MW-1:0]  mism_q, mism_d;
  logic           ffv_q, ffv_d;
  logic [VW-1:0]  ffvec_q, ffvec_d;

  logic           last_vec;
  logic           settled;
  logic           mismatch;

  assign last_vec = (vec_q == {VW{1'b1}});
  assign settled  = (settle_q == SW'(SETTLE - 1));
  assign mismatch = (y_dut != y_ref);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)   state_d = S_APPLY;
      S_APPLY:   if (settled) state_d = S_COMPARE;
      S_COMPARE: state_d = last_vec ? S_DONE : S_APPLY;
      S_DONE:    if (start)   state_d = S_APPLY;
      default:   state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      S_APPLY, S_COMPARE: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (mism_q == '0);
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    vec_d    = vec_q;
    settle_d = settle_q;
    mism_d   = mism_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = '0;
          settle_d = '0;
          mism_d   = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
        end
      end
      S_APPLY: settle_d = settle_q + SW'(1);
      S_COMPARE: begin
        if (mismatch) begin
          mism_d = mism_q + MW'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
        // The terminal vector is held so the results stay consistent in DONE.
        if (!last_vec) begin
          vec_d    = vec_q + VW'(1);
          settle_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= '0;
      settle_q <= '0;
      mism_q   <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      vec_q    <= vec_d;
      settle_q <= settle_d;
      mism_q   <= mism_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  assign a_out            = vec_q[VW-1:W];
  assign b_out            = vec_q[W-1:0];
  assign mism_cnt         = mism_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
